// File: rtl/gpioemu_prime_queue_pkg.sv
// ---------------------------------------------------------------------------
// gpioemu_prime_queue_pkg
// Shared definitions for the queued prime calculator: register offsets
// relative to the block base address, STATUS and CTRL bit positions, and the
// state encoding of the trial-division engine.
// ---------------------------------------------------------------------------
package gpioemu_prime_queue_pkg;

    // Register offsets from BASE
    localparam logic [15:0] OFF_REQ    = 16'h0000;
    localparam logic [15:0] OFF_STATUS = 16'h0008;
    localparam logic [15:0] OFF_RESULT = 16'h0010;
    localparam logic [15:0] OFF_CTRL   = 16'h0018;

    // STATUS bit positions (counts live at [23:16] and [15:8])
    localparam int ST_BUSY = 0;
    localparam int ST_OVF  = 1;
    localparam int ST_UNF  = 2;
    localparam int ST_BADN = 3;

    // CTRL bit positions
    localparam int CTRL_FLUSH    = 0;
    localparam int CTRL_CLRFLAGS = 1;
    localparam int CTRL_IRQEN    = 2;

    // Engine states
    typedef enum logic [2:0] {
        ENG_IDLE,
        ENG_LOAD,
        ENG_TEST,
        ENG_NEXT,
        ENG_DONE
    } eng_state_e;

endpackage

// File: rtl/gpioemu_prime_queue_engine.sv
// ---------------------------------------------------------------------------
// gpioemu_prime_queue_engine
// Trial-division engine: takes one ordinal N from the request FIFO and finds
// the Nth prime by testing candidates 2,3,4,... one divisor per cycle.
//
// Ports
//   clk_i       clock
//   reset_i     synchronous active-high reset
//   abort_i     flush from CTRL: drop any work in progress, back to IDLE
//   reqAvail_i  request FIFO holds at least one ordinal
//   resFull_i   result FIFO is full
//   reqData_i   ordinal at the head of the request FIFO
//   reqPop_o    pop the request FIFO head this cycle
//   resPush_o   push resData_o into the result FIFO this cycle
//   resBad_o    the pushed result is the rejection value for a bad N
//   resData_o   result value (prime, or 0 for a bad N)
//   busy_o      engine not idle, or a result push is still pending
// ---------------------------------------------------------------------------
module gpioemu_prime_queue_engine
    import gpioemu_prime_queue_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int MAX_N = 1000
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             abort_i,
    input  logic             reqAvail_i,
    input  logic             resFull_i,
    input  logic [WIDTH-1:0] reqData_i,
    output logic             reqPop_o,
    output logic             resPush_o,
    output logic             resBad_o,
    output logic [WIDTH-1:0] resData_o,
    output logic             busy_o
);

    eng_state_e       state_q;
    logic [WIDTH-1:0] n_q;
    logic [WIDTH-1:0] cand_q;
    logic [WIDTH-1:0] d_q;
    logic [WIDTH-1:0] count_q;
    logic             resPush_q;
    logic             resBad_q;
    logic [WIDTH-1:0] resData_q;

    logic [2*WIDTH-1:0] dSq;
    logic [2*WIDTH-1:0] candWide;
    logic [WIDTH-1:0]   rem;
    logic               badN;

    // d*d is formed at double width so the prime test never overflows.
    assign dSq      = {{WIDTH{1'b0}}, d_q} * {{WIDTH{1'b0}}, d_q};
    assign candWide = {{WIDTH{1'b0}}, cand_q};
    assign rem      = cand_q % d_q;
    assign badN     = (n_q == '0) || (n_q > WIDTH'(MAX_N));

    // A new request is only taken once the previous result has actually
    // landed in the result FIFO; otherwise resFull_i would be one push stale
    // and a finished result could find the FIFO full.
    assign reqPop_o  = (state_q == ENG_IDLE) && reqAvail_i && !resFull_i
                       && !resPush_q && !abort_i;
    assign resPush_o = resPush_q;
    assign resBad_o  = resBad_q;
    assign resData_o = resData_q;
    assign busy_o    = (state_q != ENG_IDLE) || resPush_q;

    // Engine FSM with its datapath; result push is a one-cycle registered pulse.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q   <= ENG_IDLE;
            n_q       <= '0;
            cand_q    <= '0;
            d_q       <= '0;
            count_q   <= '0;
            resPush_q <= 1'b0;
            resBad_q  <= 1'b0;
            resData_q <= '0;
        end else begin
            resPush_q <= 1'b0;
            resBad_q  <= 1'b0;
            if (abort_i) begin
                state_q <= ENG_IDLE;
            end else begin
                case (state_q)
                    ENG_IDLE: begin
                        if (reqPop_o) begin
                            n_q     <= reqData_i;
                            state_q <= ENG_LOAD;
                        end
                    end
                    ENG_LOAD: begin
                        if (badN) begin
                            resPush_q <= 1'b1;
                            resBad_q  <= 1'b1;
                            resData_q <= '0;
                            state_q   <= ENG_IDLE;
                        end else begin
                            cand_q  <= WIDTH'(2);
                            d_q     <= WIDTH'(2);
                            count_q <= '0;
                            state_q <= ENG_TEST;
                        end
                    end
                    ENG_TEST: begin
                        if (dSq > candWide) begin
                            count_q <= count_q + WIDTH'(1);
                            if (count_q + WIDTH'(1) == n_q) begin
                                state_q <= ENG_DONE;
                            end else begin
                                state_q <= ENG_NEXT;
                            end
                        end else if (rem == '0) begin
                            state_q <= ENG_NEXT;
                        end else begin
                            d_q <= d_q + WIDTH'(1);
                        end
                    end
                    ENG_NEXT: begin
                        cand_q  <= cand_q + WIDTH'(1);
                        d_q     <= WIDTH'(2);
                        state_q <= ENG_TEST;
                    end
                    ENG_DONE: begin
                        resPush_q <= 1'b1;
                        resData_q <= cand_q;
                        state_q   <= ENG_IDLE;
                    end
                    default: state_q <= ENG_IDLE;
                endcase
            end
        end
    end

endmodule

// File: rtl/gpioemu_prime_queue.sv
// ---------------------------------------------------------------------------
// gpioemu_prime_queue
// Bus-mapped queued prime calculator. Writes to REQ queue ordinals, the
// engine computes the Nth prime for each, results are popped via RESULT.
// Also holds the GPIO mirror/latch and the status/IRQ logic.
//
// Ports
//   clk             clock
//   n_reset         synchronous reset, active-high
//   saddress        register address
//   srd / swr       read / write strobes (level, act on rising edge)
//   sdata_in        write data
//   sdata_out       registered read data, held until the next read
//   gpio_in         GPIO inputs
//   gpio_latch      capture gpio_in while high
//   gpio_out        low 32 bits of the last completed prime
//   gpio_in_s_insp  latched gpio_in
//   irq             result FIFO non-empty and IRQ enabled
// ---------------------------------------------------------------------------
module gpioemu_prime_queue
    import gpioemu_prime_queue_pkg::*;
#(
    parameter int          WIDTH  = 32,
    parameter int          QDEPTH = 4,
    parameter int          MAX_N  = 1000,
    parameter logic [15:0] BASE   = 16'h0100
) (
    input  logic             clk,
    input  logic             n_reset,
    input  logic [15:0]      saddress,
    input  logic             srd,
    input  logic             swr,
    input  logic [WIDTH-1:0] sdata_in,
    output logic [WIDTH-1:0] sdata_out,
    input  logic [31:0]      gpio_in,
    input  logic             gpio_latch,
    output logic [31:0]      gpio_out,
    output logic [31:0]      gpio_in_s_insp,
    output logic             irq
);

    localparam int PW = $clog2(QDEPTH);
    localparam int CW = PW + 1;

    localparam logic [15:0] ADDR_REQ    = BASE + OFF_REQ;
    localparam logic [15:0] ADDR_STATUS = BASE + OFF_STATUS;
    localparam logic [15:0] ADDR_RESULT = BASE + OFF_RESULT;
    localparam logic [15:0] ADDR_CTRL   = BASE + OFF_CTRL;

    logic             srd_q, swr_q;
    logic [WIDTH-1:0] reqMem [QDEPTH];
    logic [WIDTH-1:0] resMem [QDEPTH];
    logic [PW-1:0]    reqWr_q, reqRd_q, resWr_q, resRd_q;
    logic [CW-1:0]    reqCnt_q, resCnt_q;
    logic [WIDTH-1:0] sdataOut_q;
    logic [31:0]      gpioOut_q, gpioIns_q;
    logic             ovf_q, unf_q, badn_q, irqEn_q;

    logic rdEdge, wrEdge;
    logic wrReq, wrCtrl, rdStatus, rdResult;
    logic flush, clrFlags;
    logic reqFull, reqEmpty, resFull, resEmpty;
    logic reqPush, reqPop, resPush, resPop;
    logic engPop, engPush, engBad, engBusy;
    logic [WIDTH-1:0] engData;
    logic [WIDTH-1:0] statusWord;

    // A held strobe counts as one access: only the 0->1 transition acts.
    assign rdEdge = srd && !srd_q;
    assign wrEdge = swr && !swr_q;

    assign wrReq    = wrEdge && (saddress == ADDR_REQ);
    assign wrCtrl   = wrEdge && (saddress == ADDR_CTRL);
    assign rdStatus = rdEdge && (saddress == ADDR_STATUS);
    assign rdResult = rdEdge && (saddress == ADDR_RESULT);

    assign flush    = wrCtrl && sdata_in[CTRL_FLUSH];
    assign clrFlags = wrCtrl && sdata_in[CTRL_CLRFLAGS];

    assign reqFull  = (reqCnt_q == CW'(QDEPTH));
    assign reqEmpty = (reqCnt_q == '0);
    assign resFull  = (resCnt_q == CW'(QDEPTH));
    assign resEmpty = (resCnt_q == '0);

    // Flush beats a same-cycle engine push: the result is discarded.
    assign reqPush = wrReq && !reqFull;
    assign reqPop  = engPop;
    assign resPush = engPush && !flush;
    assign resPop  = rdResult && !resEmpty;

    gpioemu_prime_queue_engine #(
        .WIDTH (WIDTH),
        .MAX_N (MAX_N)
    ) u_engine (
        .clk_i      (clk),
        .reset_i    (n_reset),
        .abort_i    (flush),
        .reqAvail_i (!reqEmpty),
        .resFull_i  (resFull),
        .reqData_i  (reqMem[reqRd_q]),
        .reqPop_o   (engPop),
        .resPush_o  (engPush),
        .resBad_o   (engBad),
        .resData_o  (engData),
        .busy_o     (engBusy)
    );

    always_comb begin
        statusWord          = '0;
        statusWord[23:16]   = 8'(reqCnt_q);
        statusWord[15:8]    = 8'(resCnt_q);
        statusWord[ST_BADN] = badn_q;
        statusWord[ST_UNF]  = unf_q;
        statusWord[ST_OVF]  = ovf_q;
        statusWord[ST_BUSY] = engBusy;
    end

    // FIFO storage is not reset; the pointers and counts define validity.
    always_ff @(posedge clk) begin
        if (reqPush) reqMem[reqWr_q] <= sdata_in;
        if (resPush) resMem[resWr_q] <= engData;
    end

    always_ff @(posedge clk) begin
        if (n_reset) begin
            srd_q      <= 1'b0;
            swr_q      <= 1'b0;
            reqWr_q    <= '0;
            reqRd_q    <= '0;
            reqCnt_q   <= '0;
            resWr_q    <= '0;
            resRd_q    <= '0;
            resCnt_q   <= '0;
            sdataOut_q <= '0;
            gpioOut_q  <= '0;
            gpioIns_q  <= '0;
            ovf_q      <= 1'b0;
            unf_q      <= 1'b0;
            badn_q     <= 1'b0;
            irqEn_q    <= 1'b0;
        end else begin
            srd_q <= srd;
            swr_q <= swr;

            if (flush) begin
                reqWr_q  <= '0;
                reqRd_q  <= '0;
                reqCnt_q <= '0;
                resWr_q  <= '0;
                resRd_q  <= '0;
                resCnt_q <= '0;
            end else begin
                // Pointers wrap naturally because QDEPTH is a power of two.
                if (reqPush) reqWr_q <= reqWr_q + PW'(1);
                if (reqPop)  reqRd_q <= reqRd_q + PW'(1);
                reqCnt_q <= reqCnt_q + CW'(reqPush) - CW'(reqPop);
                if (resPush) resWr_q <= resWr_q + PW'(1);
                if (resPop)  resRd_q <= resRd_q + PW'(1);
                resCnt_q <= resCnt_q + CW'(resPush) - CW'(resPop);
            end

            if (rdEdge) begin
                if (rdStatus) begin
                    sdataOut_q <= statusWord;
                end else if (rdResult && !resEmpty) begin
                    sdataOut_q <= resMem[resRd_q];
                end else begin
                    sdataOut_q <= '0;
                end
            end

            if (wrCtrl) irqEn_q <= sdata_in[CTRL_IRQEN];

            // Clearing happens first so a same-cycle event still leaves its flag set.
            if (clrFlags) begin
                ovf_q  <= 1'b0;
                unf_q  <= 1'b0;
                badn_q <= 1'b0;
            end
            if (wrReq && reqFull)      ovf_q  <= 1'b1;
            if (rdResult && resEmpty)  unf_q  <= 1'b1;
            if (resPush && engBad)     badn_q <= 1'b1;

            if (resPush && !engBad) gpioOut_q <= engData[31:0];
            if (gpio_latch)         gpioIns_q <= gpio_in;
        end
    end

    assign sdata_out      = sdataOut_q;
    assign gpio_out       = gpioOut_q;
    assign gpio_in_s_insp = gpioIns_q;
    assign irq            = irqEn_q && !resEmpty;

endmodule

// File: tb/tb_gpioemu_prime_queue.sv
// ---------------------------------------------------------------------------
// tb_gpioemu_prime_queue
// Scoreboard bench: bus reads push their expected value when issued; a
// monitor pops and compares when the DUT responds to the read strobe edge.
// ---------------------------------------------------------------------------
module tb_gpioemu_prime_queue;

    localparam logic [15:0] BASE    = 16'h0100;
    localparam logic [15:0] A_REQ   = BASE + 16'h00;
    localparam logic [15:0] A_STAT  = BASE + 16'h08;
    localparam logic [15:0] A_RES   = BASE + 16'h10;
    localparam logic [15:0] A_CTRL  = BASE + 16'h18;
    localparam logic [31:0] ALL     = 32'hFFFF_FFFF;

    logic        clk = 1'b0;
    logic        n_reset = 1'b1;
    logic [15:0] saddress = '0;
    logic        srd = 1'b0;
    logic        swr = 1'b0;
    logic [31:0] sdata_in = '0;
    logic [31:0] sdata_out;
    logic [31:0] gpio_in = '0;
    logic        gpio_latch = 1'b0;
    logic [31:0] gpio_out;
    logic [31:0] gpio_in_s_insp;
    logic        irq;

    int nCompared = 0;
    int nMismatched = 0;

    logic [31:0] expQ[$];
    logic [31:0] maskQ[$];
    string       nameQ[$];

    logic pending = 1'b0;
    logic prevSrd = 1'b0;

    gpioemu_prime_queue #(
        .WIDTH (32),
        .QDEPTH(4),
        .MAX_N (1000),
        .BASE  (BASE)
    ) dut (
        .clk            (clk),
        .n_reset        (n_reset),
        .saddress       (saddress),
        .srd            (srd),
        .swr            (swr),
        .sdata_in       (sdata_in),
        .sdata_out      (sdata_out),
        .gpio_in        (gpio_in),
        .gpio_latch     (gpio_latch),
        .gpio_out       (gpio_out),
        .gpio_in_s_insp (gpio_in_s_insp),
        .irq            (irq)
    );

    always #5 clk = ~clk;

    // Monitor: a rising srd seen at one negedge is answered by the DUT at the
    // following posedge, so the response is compared at the next negedge.
    always @(negedge clk) begin
        logic [31:0] e, m;
        string       nm;
        if (pending) begin
            if (expQ.size() == 0) begin
                nCompared++;
                nMismatched++;
                $display("[TB] FAIL unexpected_read: got %h, no expected entry", sdata_out);
            end else begin
                e  = expQ.pop_front();
                m  = maskQ.pop_front();
                nm = nameQ.pop_front();
                if (m != '0) begin
                    nCompared++;
                    if (((sdata_out ^ e) & m) != '0) begin
                        nMismatched++;
                        $display("[TB] FAIL %s: got %h, expected %h", nm, sdata_out, e);
                    end
                end
            end
        end
        pending = srd && !prevSrd && !n_reset;
        prevSrd = srd;
    end

    task automatic checkOutput(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nCompared++;
        if (act !== exp) begin
            nMismatched++;
            $display("[TB] FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic busWrite(input logic [15:0] addr, input logic [31:0] data);
        @(posedge clk); #1;
        saddress = addr;
        sdata_in = data;
        swr = 1'b1;
        @(posedge clk); #1;
        swr = 1'b0;
    endtask

    task automatic busRead(input logic [15:0] addr, input logic [31:0] exp,
                           input logic [31:0] mask, input string nm);
        expQ.push_back(exp);
        maskQ.push_back(mask);
        nameQ.push_back(nm);
        @(posedge clk); #1;
        saddress = addr;
        srd = 1'b1;
        @(posedge clk); #1;
        srd = 1'b0;
    endtask

    task automatic holdRead(input logic [15:0] addr, input int cycles,
                            input logic [31:0] exp, input string nm);
        expQ.push_back(exp);
        maskQ.push_back(ALL);
        nameQ.push_back(nm);
        @(posedge clk); #1;
        saddress = addr;
        srd = 1'b1;
        repeat (cycles) @(posedge clk);
        #1;
        srd = 1'b0;
    endtask

    // Poll STATUS (unchecked reads) until (status & mask) == val.
    task automatic waitStatus(input logic [31:0] mask, input logic [31:0] val,
                              input int maxPolls, input string nm);
        bit ok = 1'b0;
        for (int i = 0; i < maxPolls && !ok; i++) begin
            busRead(A_STAT, '0, '0, "poll");
            if ((sdata_out & mask) == val) ok = 1'b1;
        end
        if (!ok) begin
            nCompared++;
            nMismatched++;
            $display("[TB] FAIL %s: status %h never reached %h (mask %h)", nm, sdata_out, val, mask);
        end
    endtask

    task automatic waitIdle(input string nm);
        waitStatus(32'h00FF_0001, 32'h0, 6000, nm);
    endtask

    task automatic applyStimulus();
        // Reset state
        repeat (3) @(posedge clk);
        #1 n_reset = 1'b0;
        @(posedge clk); #1;
        checkOutput("rst_sdata_out", sdata_out, 32'h0);
        checkOutput("rst_gpio_out", gpio_out, 32'h0);
        checkOutput("rst_irq", {31'b0, irq}, 32'h0);
        busRead(A_STAT, 32'h0, ALL, "rst_status");

        // GPIO latch
        gpio_in = 32'hA5A5_1234;
        gpio_latch = 1'b1;
        @(posedge clk); #1;
        gpio_latch = 1'b0;
        gpio_in = 32'h0F0F_0F0F;
        @(posedge clk); #1;
        checkOutput("gpio_latch", gpio_in_s_insp, 32'hA5A5_1234);

        // 1: single request
        busWrite(A_REQ, 5);
        waitIdle("t1_idle");
        busRead(A_RES, 11, ALL, "t1_result");
        checkOutput("t1_gpio_out", gpio_out, 32'd11);
        checkOutput("t1_irq", {31'b0, irq}, 32'h0);

        // 2: four back-to-back requests with IRQ
        busWrite(A_REQ, 1);
        busWrite(A_REQ, 10);
        busWrite(A_REQ, 25);
        busWrite(A_REQ, 100);
        busWrite(A_CTRL, 32'h4);
        waitIdle("t2_idle");
        checkOutput("t2_irq_high", {31'b0, irq}, 32'h1);
        busRead(A_STAT, 32'h0000_0400, ALL, "t2_status");
        busRead(A_RES, 2, ALL, "t2_r1");
        busRead(A_RES, 29, ALL, "t2_r10");
        busRead(A_RES, 97, ALL, "t2_r25");
        checkOutput("t2_irq_still", {31'b0, irq}, 32'h1);
        busRead(A_RES, 541, ALL, "t2_r100");
        checkOutput("t2_irq_low", {31'b0, irq}, 32'h0);
        checkOutput("t2_gpio_out", gpio_out, 32'd541);

        // 3: overflow while the engine is busy
        busWrite(A_REQ, 100);
        for (int i = 1; i <= 6; i++) busWrite(A_REQ, i);
        busRead(A_STAT, 32'h0004_0003, ALL, "t3_status_ovf");
        waitStatus(32'h0000_FF00, 32'h0000_0400, 6000, "t3_resfull");
        busRead(A_RES, 541, ALL, "t3_r100");
        busRead(A_RES, 2, ALL, "t3_r1");
        busRead(A_RES, 3, ALL, "t3_r2");
        busRead(A_RES, 5, ALL, "t3_r3");
        waitIdle("t3_idle");
        busRead(A_RES, 7, ALL, "t3_r4");
        busRead(A_STAT, 32'h0000_0002, ALL, "t3_status_drained");
        busWrite(A_CTRL, 32'h2);
        busRead(A_STAT, 32'h0, ALL, "t3_status_clr");

        // 4: bad ordinals
        busWrite(A_REQ, 0);
        busWrite(A_REQ, 1001);
        waitIdle("t4_idle");
        busRead(A_STAT, 32'h0000_0208, ALL, "t4_status");
        busRead(A_RES, 0, ALL, "t4_bad0");
        busRead(A_RES, 0, ALL, "t4_bad1001");
        busRead(A_STAT, 32'h0000_0008, ALL, "t4_badn");
        busWrite(A_CTRL, 32'h2);
        busRead(A_STAT, 32'h0, ALL, "t4_status_clr");

        // 5: underflow and held strobe
        busRead(A_RES, 0, ALL, "t5_empty");
        busRead(A_STAT, 32'h0000_0004, ALL, "t5_unf");
        busWrite(A_REQ, 5);
        busWrite(A_REQ, 2);
        waitIdle("t5_idle");
        busRead(A_STAT, 32'h0000_0204, ALL, "t5_two");
        holdRead(A_RES, 25, 11, "t5_held");
        busRead(A_STAT, 32'h0000_0104, ALL, "t5_one_pop");
        busRead(A_RES, 3, ALL, "t5_second");
        checkOutput("t5_gpio_out", gpio_out, 32'd3);

        // 6: reset mid-computation
        busWrite(A_REQ, 450);
        repeat (200) @(posedge clk);
        #1 n_reset = 1'b1;
        repeat (3) @(posedge clk);
        #1 n_reset = 1'b0;
        @(posedge clk); #1;
        checkOutput("t6_gpio_out_rst", gpio_out, 32'h0);
        checkOutput("t6_sdata_rst", sdata_out, 32'h0);
        busRead(A_STAT, 32'h0, ALL, "t6_status_rst");
        busWrite(A_REQ, 5);
        waitIdle("t6_idle");
        busRead(A_STAT, 32'h0000_0100, ALL, "t6_status_one");
        busRead(A_RES, 11, ALL, "t6_result");
        checkOutput("t6_gpio_out", gpio_out, 32'd11);
        busRead(A_STAT, 32'h0, ALL, "t6_status_empty");
    endtask

    initial begin
        applyStimulus();
        repeat (4) @(posedge clk);
        if (expQ.size() != 0) begin
            nCompared++;
            nMismatched++;
            $display("[TB] FAIL scoreboard_drain: %0d entries left, expected 0", expQ.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
